enigma_sched: RTL and testbench

//  Character scheduler for the rotor chain. Accepts one ASCII letter at a time, steps the rotors

---
 rtl/enigma_sched.sv | 229 ++++++++++++++++++++++
 tb/tb_enigma_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_sched.sv
// Character scheduler for the rotor chain: accepts one ASCII letter, steps the
// rotor position counters odometer-style, walks the letter forward through the
// rotors, through the fixed reflector, back through the rotors, and presents
// the resulting character. Exactly one letter is in flight at a time.
module enigma_sched #(
   parameter int NROT    = 3,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                in_valid,
   input  logic [7:0]          in_char,
   output logic                in_ready,
   output logic                out_valid,
   output logic [7:0]          out_char,
   input  logic                out_ready,
   input  logic                pos_clr,
   output logic [NROT-1:0]     rot_en,
   output logic [NROT-1:0]     rot_valid,
   output logic                rot_dec,
   output logic [7:0]          rot_din,
   input  logic [8*NROT-1:0]   rot_dout,
   input  logic [NROT-1:0]     rot_done,
   output logic [5*NROT-1:0]   pos,
   output logic                err
);

   localparam int KW = (NROT > 1) ? $clog2(NROT) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [KW-1:0] K_LAST = KW'(NROT - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      STEP      = 3'd1,
      FWD_ISSUE = 3'd2,
      FWD_WAIT  = 3'd3,
      REFL      = 3'd4,
      BWD_ISSUE = 3'd5,
      BWD_WAIT  = 3'd6,
      OUT       = 3'd7
   } state_t;

   state_t              state_r, state_n;
   logic [7:0]          cur_r, cur_n;
   logic [KW-1:0]       k_r, k_n;
   logic [TW-1:0]       timer_r, timer_n;
   logic [5*NROT-1:0]   pos_r, pos_n;
   logic                err_r, err_n;

   logic                in_ready_r;
   logic                out_valid_r;
   logic [NROT-1:0]     rot_en_r;
   logic [NROT-1:0]     rot_valid_r;
   logic                rot_dec_r;

   logic                sel_done_s;
   logic [7:0]          sel_dout_s;

   // Rotor k steps when every faster rotor (index below k) sits at 25.
   function automatic logic [NROT-1:0] step_mask(input logic [5*NROT-1:0] p);
      logic [NROT-1:0] m;
      logic            carry;
      carry = 1'b1;
      for (int k = 0; k < NROT; k++) begin
         m[k]  = carry;
         carry = carry & (p[5*k +: 5] == 5'd25);
      end
      return m;
   endfunction

   // Advance the masked position counters, wrapping 25 back to 0.
   function automatic logic [5*NROT-1:0] step_pos(input logic [5*NROT-1:0] p,
                                                  input logic [NROT-1:0]   m);
      logic [5*NROT-1:0] r;
      r = p;
      for (int k = 0; k < NROT; k++) begin
         if (m[k]) begin
            r[5*k +: 5] = (p[5*k +: 5] == 5'd25) ? 5'd0 : p[5*k +: 5] + 5'd1;
         end else begin
            r[5*k +: 5] = p[5*k +: 5];
         end
      end
      return r;
   endfunction

   function automatic logic is_letter(input logic [7:0] c);
      return (c >= 8'd65) && (c <= 8'd90);
   endfunction

   assign sel_done_s = rot_done[k_r];
   assign sel_dout_s = rot_dout[8*k_r +: 8];

   // Next-state, datapath and timeout decisions for the letter sequencer.
   always_comb begin
      state_n = state_r;
      cur_n   = cur_r;
      k_n     = k_r;
      timer_n = timer_r;
      pos_n   = pos_r;
      err_n   = err_r;
      case (state_r)
         IDLE: begin
            // Clear first so an accept in the same cycle steps from zero.
            if (pos_clr) begin
               pos_n = '0;
            end else begin
               pos_n = pos_r;
            end
            if (in_valid && in_ready_r) begin
               cur_n   = in_char;
               state_n = is_letter(in_char) ? STEP : OUT;
            end else begin
               state_n = IDLE;
            end
         end
         STEP: begin
            pos_n   = step_pos(pos_r, step_mask(pos_r));
            k_n     = '0;
            state_n = FWD_ISSUE;
         end
         FWD_ISSUE: begin
            timer_n = '0;
            state_n = FWD_WAIT;
         end
         FWD_WAIT: begin
            if (sel_done_s) begin
               cur_n = sel_dout_s;
               if (k_r == K_LAST) begin
                  state_n = REFL;
               end else begin
                  k_n     = k_r + KW'(1);
                  state_n = FWD_ISSUE;
               end
            end else if (timer_r == T_LAST) begin
               err_n   = 1'b1;
               state_n = IDLE;
            end else begin
               timer_n = timer_r + TW'(1);
            end
         end
         REFL: begin
            // A<->Z, B<->Y ... M<->N; 'A'+'Z' = 155.
            cur_n   = 8'd155 - cur_r;
            k_n     = K_LAST;
            state_n = BWD_ISSUE;
         end
         BWD_ISSUE: begin
            timer_n = '0;
            state_n = BWD_WAIT;
         end
         BWD_WAIT: begin
            if (sel_done_s) begin
               cur_n = sel_dout_s;
               if (k_r == KW'(0)) begin
                  state_n = OUT;
               end else begin
                  k_n     = k_r - KW'(1);
                  state_n = BWD_ISSUE;
               end
            end else if (timer_r == T_LAST) begin
               err_n   = 1'b1;
               state_n = IDLE;
            end else begin
               timer_n = timer_r + TW'(1);
            end
         end
         OUT: begin
            if (out_ready) begin
               state_n = IDLE;
            end else begin
               state_n = OUT;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Sequencer state and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         cur_r   <= 8'd0;
         k_r     <= '0;
         timer_r <= '0;
         pos_r   <= '0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_n;
         cur_r   <= cur_n;
         k_r     <= k_n;
         timer_r <= timer_n;
         pos_r   <= pos_n;
         err_r   <= err_n;
      end
   end

   // Interface outputs registered from the next state so they line up with it.
   // in_ready comes up one cycle after reset release; acceptance is gated on it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         rot_en_r    <= '0;
         rot_valid_r <= '0;
         rot_dec_r   <= 1'b0;
      end else begin
         in_ready_r  <= (state_n == IDLE);
         out_valid_r <= (state_n == OUT);
         rot_en_r    <= (state_n == STEP) ? step_mask(pos_n) : '0;
         rot_valid_r <= ((state_n == FWD_ISSUE) || (state_n == BWD_ISSUE)) ?
                        (NROT'(1) << k_n) : '0;
         rot_dec_r   <= (state_n == BWD_ISSUE) || (state_n == BWD_WAIT);
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_char  = cur_r;
   assign rot_en    = rot_en_r;
   assign rot_valid = rot_valid_r;
   assign rot_dec   = rot_dec_r;
   assign rot_din   = cur_r;
   assign pos       = pos_r;
   assign err       = err_r;

endmodule

// File: tb/tb_enigma_sched.sv
// Directed bench for enigma_sched with behavioural stub rotors (identity or
// +/-1 Caesar shift, configurable response delay, per-rotor "dead" mask).
module tb_enigma_sched;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_char = 8'd0;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_char;
   logic        out_ready = 1'b0;
   logic        pos_clr = 1'b0;
   logic [2:0]  rot_en;
   logic [2:0]  rot_valid;
   logic        rot_dec;
   logic [7:0]  rot_din;
   logic [23:0] rot_dout = 24'd0;
   logic [2:0]  rot_done = 3'd0;
   logic [14:0] pos;
   logic        err;

   enigma_sched #(.NROT(3), .TIMEOUT(64)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
      .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready),
      .pos_clr(pos_clr), .rot_en(rot_en), .rot_valid(rot_valid),
      .rot_dec(rot_dec), .rot_din(rot_din), .rot_dout(rot_dout),
      .rot_done(rot_done), .pos(pos), .err(err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- stub rotors ----------------
   int         w = 2;
   logic       shift = 1'b0;
   logic [2:0] dead = 3'b000;
   int         cnt [3] = '{0, 0, 0};
   logic [7:0] din_l [3];
   logic       dec_l [3];

   function automatic logic [7:0] rmap(input logic [7:0] c, input logic d);
      if (!shift) return c;
      if (!d) return (c == 8'd90) ? 8'd65 : c + 8'd1;
      return (c == 8'd65) ? 8'd90 : c - 8'd1;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         rot_done[k] <= 1'b0;
         if (rot_valid[k] && !dead[k]) begin
            if (w == 1) begin
               rot_done[k]       <= 1'b1;
               rot_dout[8*k +: 8] <= rmap(rot_din, rot_dec);
            end else begin
               cnt[k]   <= w - 1;
               din_l[k] <= rot_din;
               dec_l[k] <= rot_dec;
            end
         end else if (cnt[k] == 1) begin
            rot_done[k]       <= 1'b1;
            rot_dout[8*k +: 8] <= rmap(din_l[k], dec_l[k]);
            cnt[k]            <= 0;
         end else if (cnt[k] > 1) begin
            cnt[k] <= cnt[k] - 1;
         end
      end
   end

   // ---------------- monitor ----------------
   int          cyc = 0;
   int          t0 = 0;
   int          t_rv1 = 0;
   int          t_err = 0;
   logic        err_seen = 1'b0;
   logic [2:0]  en_acc = 3'd0;
   logic [17:0] rv_seq = 18'd0;
   int          rv_n = 0;
   logic        seen = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (in_valid && in_ready) begin
         t0     <= cyc;
         en_acc <= 3'd0;
         rv_seq <= 18'd0;
         rv_n   <= 0;
         seen   <= 1'b0;
      end else begin
         en_acc <= en_acc | rot_en;
         if (|rot_valid) begin
            rv_n   <= rv_n + 1;
            rv_seq <= {rv_seq[14:0], rot_dec,
                       rot_valid[2] ? 2'd2 : (rot_valid[1] ? 2'd1 : 2'd0)};
         end
         if (out_valid) seen <= 1'b1;
      end
      if (rot_valid[1]) t_rv1 <= cyc;
      if (err && !err_seen) begin
         err_seen <= 1'b1;
         t_err    <= cyc;
      end
   end

   // ---------------- driver ----------------
   task automatic send(input logic [7:0] c, input logic clr, input logic wait_out,
                       input int hold, input logic do_chk, input logic [7:0] exp,
                       input int exp_lat);
      int guard;
      int tout;
      guard = 0;
      while (!in_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         check("in_ready_wait", {31'd0, in_ready}, 32'd1);
         return;
      end
      in_valid = 1'b1;
      in_char  = c;
      pos_clr  = clr;
      @(negedge clk);
      in_valid = 1'b0;
      pos_clr  = 1'b0;
      if (!wait_out) return;
      guard = 0;
      while (!out_valid && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      tout = cyc;
      if (!out_valid) begin
         check("out_valid_wait", {31'd0, out_valid}, 32'd1);
         return;
      end
      if (do_chk) begin
         check("out_char", {24'd0, out_char}, {24'd0, exp});
         if (exp_lat >= 0) check("latency", tout - t0, exp_lat);
      end
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_char  = 8'd81;
         @(negedge clk);
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         check("bp_char", {24'd0, out_char}, {24'd0, exp});
         check("bp_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int guard;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // 1: reset in the middle of a forward wait
      dead = 3'b111;
      send(8'd65, 1'b0, 1'b0, 0, 1'b0, 8'd0, -1);
      repeat (5) @(negedge clk);
      check("pre_rst_pos", {17'd0, pos}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("rst_rot_valid", {29'd0, rot_valid}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      dead = 3'b000;
      repeat (2) @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_pos", {17'd0, pos}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_rot_en", {29'd0, rot_en}, 32'd0);
      repeat (10) @(negedge clk);
      check("rst_no_out", {31'd0, out_valid}, 32'd0);

      // 2: identity rotors, W=2
      w = 2; shift = 1'b0;
      send(8'd65, 1'b0, 1'b1, 0, 1'b1, 8'd90, 21);
      check("rv_seq", {14'd0, rv_seq}, {14'd0, 18'b000_001_010_110_101_100});
      check("step_en", {29'd0, en_acc}, 32'd1);
      check("pos_1", {17'd0, pos}, 32'd1);
      send(8'd77, 1'b0, 1'b1, 0, 1'b1, 8'd78, 21);
      // Caesar stubs: A -> D -> W -> T, Z -> C -> X -> U
      shift = 1'b1;
      send(8'd65, 1'b0, 1'b1, 0, 1'b1, 8'd84, 21);
      send(8'd90, 1'b0, 1'b1, 0, 1'b1, 8'd85, 21);
      check("pos_4", {17'd0, pos}, 32'd4);
      shift = 1'b0;

      // 4: non-letter passes straight through
      send(8'h31, 1'b0, 1'b1, 0, 1'b1, 8'h31, 1);
      check("nl_rot_en", {29'd0, en_acc}, 32'd0);
      check("nl_rot_valid", rv_n, 32'd0);
      check("nl_pos", {17'd0, pos}, 32'd4);

      // 6: backpressure for 10 cycles, B -> Y
      send(8'd66, 1'b0, 1'b1, 10, 1'b1, 8'd89, 21);
      check("bp_pos", {17'd0, pos}, 32'd5);

      // 5: rotor 1 never answers
      dead = 3'b010;
      send(8'd67, 1'b0, 1'b0, 0, 1'b0, 8'd0, -1);
      guard = 0;
      while (!err && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      check("to_err", {31'd0, err}, 32'd1);
      @(negedge clk);
      check("to_delay", t_err - t_rv1, 32'd65);
      check("to_in_ready", {31'd0, in_ready}, 32'd1);
      check("to_no_out", {31'd0, seen}, 32'd0);
      check("to_pos", {17'd0, pos}, 32'd6);
      dead = 3'b000;
      send(8'd67, 1'b0, 1'b1, 0, 1'b1, 8'd88, 21);
      check("err_sticky", {31'd0, err}, 32'd1);
      check("to_pos_next", {17'd0, pos}, 32'd7);

      // 3: carries; clear and accept in the same cycle first
      w = 1;
      send(8'd65, 1'b1, 1'b1, 0, 1'b1, 8'd90, 15);
      check("clr_acc_en", {29'd0, en_acc}, 32'd1);
      check("clr_acc_pos", {17'd0, pos}, 32'd1);
      for (int i = 0; i < 24; i++) send(8'd65, 1'b0, 1'b1, 0, 1'b0, 8'd0, -1);
      send(8'd65, 1'b0, 1'b1, 0, 1'b1, 8'd90, 15);
      check("carry1_en", {29'd0, en_acc}, 32'd3);
      check("carry1_pos", {17'd0, pos}, {17'd0, 5'd0, 5'd1, 5'd0});
      for (int i = 0; i < 649; i++) send(8'd65, 1'b0, 1'b1, 0, 1'b0, 8'd0, -1);
      check("pre_carry2_pos", {17'd0, pos}, {17'd0, 5'd0, 5'd25, 5'd25});
      send(8'd65, 1'b0, 1'b1, 0, 1'b1, 8'd90, 15);
      check("carry2_en", {29'd0, en_acc}, 32'd7);
      check("carry2_pos", {17'd0, pos}, {17'd0, 5'd1, 5'd0, 5'd0});

      // plain clear while idle
      @(negedge clk);
      pos_clr = 1'b1;
      @(negedge clk);
      pos_clr = 1'b0;
      check("clr_pos", {17'd0, pos}, 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
